store_buffer: RTL and testbench

- Posted-write buffer directly downstream of the store byte-enable stage in the P7 pipeline.
- Accepts each byte-enabled store (address, replicated data, byteen) from the MEM stage in one cycle.
- Queues stores and drains them one at a time to the data-memory/bridge port with a req/ack handshake, so a slow memory or device does not stall the pipeline.
- Stalls loads that hit a word still pending in the buffer.

---
 rtl/store_buffer.sv | 154 +++++++++++++++
 tb/tb_store_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues byte-enabled stores and drains them in order over a req/ack port.
// Optional SB_MERGE_EN: stores to the newest queued word coalesce into that entry.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_byteen,
  output logic        wr_ready,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  output logic        sb_empty
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q, state_d;

  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic push_hit, full, merge, alloc, issue;

  assign push_hit = wr_valid & (wr_byteen != 4'b0000);
  assign full     = (count_q == FULL_CNT);

`ifdef SB_MERGE_EN
  logic [PTR_W-1:0] tail_m1;
  assign tail_m1 = tail_q - 1'b1;
  // Do not merge into an entry that is being popped into the mem registers on this edge.
  assign merge = push_hit && (count_q != '0) && (addr_q[tail_m1] == wr_addr[31:2]) &&
                 !(issue && count_q == (PTR_W+1)'(1));
`else
  assign merge = 1'b0;
`endif

  assign wr_ready = ~full | merge;
  assign alloc    = push_hit & ~full & ~merge;
  assign count_d  = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(issue);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_BUSY;
      S_BUSY: if (mem_ack && count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: issue decision and next values of the registered memory port
  always_comb begin
    issue       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    case (state_q)
      S_IDLE: issue = (count_q != '0);
      S_BUSY: begin
        if (mem_ack) begin
          issue = (count_q != '0);
          if (count_q == '0) mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (issue) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = {addr_q[head_q], 2'b00};
      mem_wdata_d = data_q[head_q];
      mem_be_d    = be_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if (alloc) tail_q <= tail_q + 1'b1;
      if (issue) head_q <= head_q + 1'b1;
    end
  end

  // Entry payload carries no reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= wr_addr[31:2];
      data_q[tail_q] <= wr_data;
      be_q[tail_q]   <= wr_byteen;
    end
`ifdef SB_MERGE_EN
    else if (merge) begin
      for (int b = 0; b < 4; b++)
        if (wr_byteen[b]) data_q[tail_m1][8*b +: 8] <= wr_data[8*b +: 8];
      be_q[tail_m1] <= be_q[tail_m1] | wr_byteen;
    end
`endif
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    logic             hit;
    hit = mem_req_q && (mem_addr_q[31:2] == ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if (({1'b0, off} < count_q) && (addr_q[i] == ld_addr[31:2])) hit = 1'b1;
    end
    ld_stall = ld_check & hit;
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_byteen = mem_be_q;
  assign sb_empty   = (count_q == '0) & ~mem_req_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); merge case runs when SB_MERGE_EN is defined.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset, wr_valid, ld_check, mem_ack;
  logic [31:0] wr_addr, wr_data, ld_addr;
  logic [3:0]  wr_byteen;
  logic        wr_ready, ld_stall, mem_req, sb_empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byteen;

  int n_cmp = 0;
  int n_bad = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteen(wr_byteen),
    .wr_ready(wr_ready),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_ack(mem_ack), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid  = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    wr_byteen = be;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_byteen = '0;
    ld_check = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    repeat (2) step();

    // reset state
    ld_check = 1'b1; #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_byteen), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_ld_stall", 32'(ld_stall), 32'd0);
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    ld_check = 1'b0;
    reset = 1'b0;
    step();

    // single sw, ack tied high: mem_req one cycle after the push edge
    mem_ack = 1'b1;
    drive(32'h10, 32'h12345678, 4'b1111); step(); wr_valid = 1'b0; #1;
    check("sw_not_yet_req", 32'(mem_req), 32'd0);
    check("sw_sb_not_empty", 32'(sb_empty), 32'd0);
    step();
    check("sw_req", 32'(mem_req), 32'd1);
    check("sw_addr", mem_addr, 32'h10);
    check("sw_wdata", mem_wdata, 32'h12345678);
    check("sw_be", 32'(mem_byteen), 32'hF);
    step();
    check("sw_req_done", 32'(mem_req), 32'd0);
    check("sw_empty_after", 32'(sb_empty), 32'd1);

    // zero byteen store is dropped
    drive(32'h50, 32'hDEADBEEF, 4'b0000); #1;
    check("be0_ready", 32'(wr_ready), 32'd1);
    step(); wr_valid = 1'b0; step();
    check("be0_empty", 32'(sb_empty), 32'd1);
    check("be0_no_req", 32'(mem_req), 32'd0);

    // fill: 1 in flight + 4 queued, sixth refused, then ordered drain
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(32'h100 + 32'(4*k), 32'hA0 + 32'(k), 4'b1111); #1;
      check("fill_ready", 32'(wr_ready), 32'd1);
      step();
    end
    drive(32'h400, 32'hBAD, 4'b1111); #1;
    check("fill_full", 32'(wr_ready), 32'd0);
    check("fill_inflight", mem_addr, 32'h100);
    step(); wr_valid = 1'b0;
    mem_ack = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      check("drain_req", 32'(mem_req), 32'd1);
      check("drain_addr", mem_addr, 32'h100 + 32'(4*k));
      check("drain_data", mem_wdata, 32'hA0 + 32'(k));
      step();
    end
    check("drain_req_off", 32'(mem_req), 32'd0);
    check("drain_empty", 32'(sb_empty), 32'd1);
    step();
    check("drain_no_sixth", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // load hazard on a queued then in-flight sb
    drive(32'h20, 32'h00AB0000, 4'b0100); step(); wr_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h23; #1;
    check("ld_hit_queued", 32'(ld_stall), 32'd1);
    ld_addr = 32'h24; #1;
    check("ld_miss_next", 32'(ld_stall), 32'd0);
    step();
    ld_addr = 32'h23; #1;
    check("ld_hit_inflight", 32'(ld_stall), 32'd1);
    check("ld_inflight_be", 32'(mem_byteen), 32'h4);
    mem_ack = 1'b1; step(); #1;
    check("ld_after_ack", 32'(ld_stall), 32'd0);
    mem_ack = 1'b0; ld_check = 1'b0;

    // full buffer, ack and push in the same cycle
    for (int k = 0; k < 5; k++) begin
      drive(32'h200 + 32'(4*k), 32'hC0 + 32'(k), 4'b1111); step();
    end
    drive(32'h300, 32'hC5, 4'b1111); mem_ack = 1'b1; #1;
    check("fa_refused", 32'(wr_ready), 32'd0);
    step(); mem_ack = 1'b0; #1;
    check("fa_ready_next", 32'(wr_ready), 32'd1);
    check("fa_issue_s1", mem_addr, 32'h204);
    step(); wr_valid = 1'b0; #1;
    check("fa_full_again", 32'(wr_ready), 32'd0);
    mem_ack = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      check("fa_drain_addr", mem_addr, (k == 4) ? 32'h300 : 32'h204 + 32'(4*k));
      check("fa_drain_data", mem_wdata, 32'hC1 + 32'(k));
      step();
    end
    check("fa_done", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // reset while a request is outstanding with 3 queued
    for (int k = 0; k < 4; k++) begin
      drive(32'h500 + 32'(4*k), 32'hE0 + 32'(k), 4'b1111); step();
    end
    wr_valid = 1'b0; #1;
    check("mr_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1; step(); reset = 1'b0; #1;
    check("mr_req_cleared", 32'(mem_req), 32'd0);
    check("mr_empty", 32'(sb_empty), 32'd1);
    check("mr_addr_cleared", mem_addr, 32'h0);
    mem_ack = 1'b1;
    repeat (3) step();
    check("mr_no_stale", 32'(mem_req), 32'd0);
    check("mr_still_empty", 32'(sb_empty), 32'd1);
    mem_ack = 1'b0;

`ifdef SB_MERGE_EN
    // merge into newest queued entry while another store is in flight
    drive(32'h40, 32'h11111111, 4'b1111); step();
    drive(32'h30, 32'h000000AA, 4'b0001); step();
    drive(32'h31, 32'h0000BB00, 4'b0010); step(); wr_valid = 1'b0;
    mem_ack = 1'b1; #1;
    check("mg_inflight", mem_addr, 32'h40);
    step();
    check("mg_addr", mem_addr, 32'h30);
    check("mg_be", 32'(mem_byteen), 32'h3);
    check("mg_data_lo", 32'(mem_wdata[15:0]), 32'hBBAA);
    step();
    check("mg_single_entry", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
